clock_step_ctrl: RTL and testbench

Front-panel controller that produces the `change` and `step` inputs for the CPU clock-state block from raw push buttons. It synchronizes and debounces the mode and step buttons, tracks whether the CPU clock is in manual (single-step) mode, and generates clean, fixed-width step pulses, singly or in bursts of N. It sits between the board buttons and the clock-state block in the board top level.

---
 rtl/clock_step_ctrl_pkg.sv | 14 +
 rtl/btn_debounce.sv | 59 +++++
 rtl/clock_step_ctrl.sv | 129 ++++++++++++
 tb/tb_clock_step_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_step_ctrl_pkg.sv
// Shared definitions for the front-panel clock step controller: step FSM
// encodings and the default timing values also used by the board top.
package clock_step_ctrl_pkg;

  localparam int DEB_CNT_DEFAULT   = 50000;
  localparam int STEP_HIGH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } step_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability-count debouncer and a
// registered one-cycle pulse on each accepted rising level.
module btn_debounce #(
  parameter int DEB_CNT = 50000,
  parameter int DEB_W   = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CNT - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_dly_q;
  logic             rise_q;
  logic [DEB_W-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronized input disagrees with the
  // accepted level; any agreeing sample restarts the stability window.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      rise_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      rise_q      <= level_q & ~level_dly_q;
      cnt_q       <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/clock_step_ctrl.sv
// Front-panel controller: debounces mode/step buttons, tracks manual mode and
// issues fixed-width step pulses, singly or in bursts.
module clock_step_ctrl
  import clock_step_ctrl_pkg::*;
#(
  parameter int DEB_CNT   = DEB_CNT_DEFAULT,
  parameter int DEB_W     = 16,
  parameter int STEP_HIGH = STEP_HIGH_DEFAULT,
  parameter int BURST_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               btn_mode,
  input  logic               btn_step,
  input  logic               burst_en,
  input  logic [BURST_W-1:0] burst_len,
  output logic               change,
  output logic               step,
  output logic               manual_mode,
  output logic               busy,
  output logic [15:0]        step_count
);

  localparam int            PH_W    = (STEP_HIGH > 1) ? $clog2(STEP_HIGH) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(STEP_HIGH - 1);

  logic mode_rise, step_rise;
  logic step_level_unused;

  step_state_e        state_q, state_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [BURST_W-1:0] remaining_q, remaining_d;
  logic [15:0]        count_q, count_d;
  logic               manual_q, manual_d;
  logic               step_q, step_d;
  logic               busy_q, busy_d;

  btn_debounce #(.DEB_CNT(DEB_CNT), .DEB_W(DEB_W)) u_mode_deb (
    .clock   (clock),
    .reset   (reset),
    .btn_i   (btn_mode),
    .level_o (change),
    .rise_o  (mode_rise)
  );

  btn_debounce #(.DEB_CNT(DEB_CNT), .DEB_W(DEB_W)) u_step_deb (
    .clock   (clock),
    .reset   (reset),
    .btn_i   (btn_step),
    .level_o (step_level_unused),
    .rise_o  (step_rise)
  );

  // A mode press always wins: it toggles the mode and aborts any pulse train.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    remaining_d = remaining_q;
    count_d     = count_q;
    manual_d    = manual_q;
    if (mode_rise) begin
      manual_d = ~manual_q;
      state_d  = ST_IDLE;
      phase_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (step_rise && manual_q) begin
            state_d     = ST_HIGH;
            phase_d     = '0;
            remaining_d = (burst_en && (burst_len != '0)) ? burst_len : BURST_W'(1);
            count_d     = count_q + 16'd1;
          end
        end
        ST_HIGH: begin
          if (phase_q == PH_LAST) begin
            state_d = ST_LOW;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        ST_LOW: begin
          if (phase_q == PH_LAST) begin
            phase_d     = '0;
            remaining_d = remaining_q - 1'b1;
            if (remaining_q == BURST_W'(1)) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_HIGH;
              count_d = count_q + 16'd1;
            end
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    step_d = (state_d == ST_HIGH);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      remaining_q <= '0;
      count_q     <= '0;
      manual_q    <= 1'b0;
      step_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      remaining_q <= remaining_d;
      count_q     <= count_d;
      manual_q    <= manual_d;
      step_q      <= step_d;
      busy_q      <= busy_d;
    end
  end

  assign step        = step_q;
  assign busy        = busy_q;
  assign manual_mode = manual_q;
  assign step_count  = count_q;

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Self-checking bench for clock_step_ctrl: directed scenarios plus random
// button activity, compared every cycle against a pulse-schedule model.
module tb_clock_step_ctrl;

  localparam int DEB = 4;
  localparam int SH  = 2;
  localparam int PER = 2 * SH;

  logic        clock     = 1'b0;
  logic        reset     = 1'b1;
  logic        btn_mode  = 1'b0;
  logic        btn_step  = 1'b0;
  logic        burst_en  = 1'b0;
  logic [7:0]  burst_len = 8'd0;
  logic        change, step, manual_mode, busy;
  logic [15:0] step_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  clock_step_ctrl #(.DEB_CNT(DEB), .DEB_W(16), .STEP_HIGH(SH), .BURST_W(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .btn_mode    (btn_mode),
    .btn_step    (btn_step),
    .burst_en    (burst_en),
    .burst_len   (burst_len),
    .change      (change),
    .step        (step),
    .manual_mode (manual_mode),
    .busy        (busy),
    .step_count  (step_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Buttons: index 0 = mode, 1 = step. A burst is a schedule: elapsed cycles
  // since start, pulse k high for elapsed in [k*PER, k*PER+SH).
  bit          m_lvl[2], m_lvl_prev[2], m_rise[2];
  int          m_run[2];
  bit          m_pipe0[$], m_pipe1[$];
  bit          m_manual, m_active;
  int          m_elapsed, m_n;
  logic [15:0] m_count;

  function automatic void model_reset();
    for (int b = 0; b < 2; b++) begin
      m_lvl[b] = 0; m_lvl_prev[b] = 0; m_rise[b] = 0; m_run[b] = 0;
    end
    m_pipe0 = '{1'b0, 1'b0};
    m_pipe1 = '{1'b0, 1'b0};
    m_manual = 0; m_active = 0; m_elapsed = 0; m_n = 0; m_count = 16'h0000;
  endfunction

  initial model_reset();

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      model_reset();
    end else begin
      bit s[2];
      if (m_rise[0]) begin
        m_manual = !m_manual;
        m_active = 0;
      end else if (m_active) begin
        m_elapsed++;
        if (m_elapsed == PER * m_n) m_active = 0;
        else if (m_elapsed % PER == 0) m_count = m_count + 16'd1;
      end else if (m_rise[1] && m_manual) begin
        m_active  = 1;
        m_elapsed = 0;
        m_n       = (burst_en && burst_len != 0) ? int'(burst_len) : 1;
        m_count   = m_count + 16'd1;
      end
      s[0] = m_pipe0.pop_front(); m_pipe0.push_back(btn_mode);
      s[1] = m_pipe1.pop_front(); m_pipe1.push_back(btn_step);
      for (int b = 0; b < 2; b++) begin
        m_rise[b]     = m_lvl[b] && !m_lvl_prev[b];
        m_lvl_prev[b] = m_lvl[b];
        if (s[b] == m_lvl[b]) m_run[b] = 0;
        else m_run[b]++;
        if (m_run[b] == DEB) begin
          m_lvl[b] = !m_lvl[b];
          m_run[b] = 0;
        end
      end
    end
  end

  wire m_step = m_active && ((m_elapsed % PER) < SH);

  always @(negedge clock) begin
    if (!reset) begin
      check("model_change", change, m_lvl[0]);
      check("model_step", step, m_step);
      check("model_manual", manual_mode, m_manual);
      check("model_busy", busy, m_active);
      check("model_count", step_count, m_count);
    end
  end

  // ---------------- monitors ----------------
  int mon_busy = 0, mon_high = 0, man_tog = 0;
  logic man_prev = 1'b0;
  always @(negedge clock) begin
    if (!reset) begin
      if (busy) mon_busy++;
      if (step) mon_high++;
      if (manual_mode !== man_prev) man_tog++;
      man_prev = manual_mode;
    end
  end

  task automatic clear_mon();
    @(posedge clock); #1;
    mon_busy = 0; mon_high = 0;
  endtask

  task automatic press(input int b, input int hold);
    @(negedge clock);
    if (b == 0) btn_mode = 1'b1; else btn_step = 1'b1;
    repeat (hold) @(negedge clock);
    if (b == 0) btn_mode = 1'b0; else btn_step = 1'b0;
    repeat (hold) @(negedge clock);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy && t < 300) begin @(negedge clock); t++; end
    check({name, "_idle_timeout"}, t < 300, 1);
  endtask

  task automatic measure(input string name, input int exp_high, input int exp_busy, input int exp_d);
    logic [15:0] base;
    clear_mon();
    base = m_count;
    press(1, 8);
    wait_idle(name);
    repeat (2) @(negedge clock);
    check({name, "_high_cycles"}, mon_high, exp_high);
    check({name, "_busy_cycles"}, mon_busy, exp_busy);
    check({name, "_count"}, step_count, 16'(base + 16'(exp_d)));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks", n_checks);
    $fatal(1);
  end

  initial begin
    int e, t, x;
    logic [15:0] base;

    repeat (3) @(negedge clock);
    check("reset_change", change, 0);
    check("reset_step", step, 0);
    check("reset_manual", manual_mode, 0);
    check("reset_busy", busy, 0);
    check("reset_count", step_count, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    man_tog = 0;

    // Bounce rejection on the mode button
    btn_mode = 1'b1; repeat (2) @(negedge clock);
    btn_mode = 1'b0; repeat (2) @(negedge clock);
    btn_mode = 1'b1;
    e = 0;
    while (!change && e < 50) begin @(posedge clock); e++; #1; end
    check("bounce_latency", e, 6);
    repeat (4) @(negedge clock);
    check("bounce_manual", manual_mode, 1);
    check("bounce_toggles", man_tog, 1);
    btn_mode = 1'b0;
    repeat (10) @(negedge clock);

    // Single step, bursts, second press ignored mid-burst
    burst_en = 1'b0; burst_len = 8'd3;
    measure("single", SH, PER, 1);
    burst_en = 1'b1; burst_len = 8'd3;
    measure("burst3", 3 * SH, 3 * PER, 3);
    burst_len = 8'd8;
    clear_mon();
    base = m_count;
    press(1, 8);
    press(1, 8);
    wait_idle("burst8");
    repeat (2) @(negedge clock);
    check("burst8_high_cycles", mon_high, 8 * SH);
    check("burst8_busy_cycles", mon_busy, 8 * PER);
    check("burst8_count", step_count, 16'(base + 16'd8));

    // Zero-length burst, step ignored outside manual mode
    burst_len = 8'd0;
    measure("len0", SH, PER, 1);
    press(0, 8);
    check("leave_manual", manual_mode, 0);
    measure("auto_mode", 0, 0, 0);
    press(0, 8);
    check("reenter_manual", manual_mode, 1);

    // Abort mid-burst with a mode press
    burst_len = 8'd5;
    x = int'($urandom_range(0, 3));
    base = m_count;
    @(negedge clock); btn_step = 1'b1;
    t = 0;
    while (!busy && t < 50) begin @(negedge clock); t++; end
    check("abort_busy_timeout", t < 50, 1);
    repeat (x) @(negedge clock);
    btn_mode = 1'b1;
    t = 0;
    while (manual_mode && t < 50) begin @(negedge clock); t++; end
    check("abort_manual_timeout", t < 50, 1);
    check("abort_step", step, 0);
    check("abort_busy", busy, 0);
    check("abort_count_range", (16'(step_count - base) == 16'd2) || (16'(step_count - base) == 16'd3), 1);
    btn_mode = 1'b0; btn_step = 1'b0;
    repeat (12) @(negedge clock);

    // Random button activity against the model
    for (int i = 0; i < 30; i++) begin
      int act;
      act = int'($urandom_range(0, 3));
      burst_en  = 1'($urandom_range(0, 1));
      burst_len = 8'($urandom_range(0, 4));
      case (act)
        0: press(1, int'($urandom_range(5, 10)));
        1: press(0, int'($urandom_range(5, 10)));
        2: for (int k = 0; k < 6; k++) begin
             @(negedge clock);
             btn_step = 1'($urandom_range(0, 1));
             btn_mode = ($urandom_range(0, 3) == 0);
           end
        default: repeat (int'($urandom_range(1, 20))) @(negedge clock);
      endcase
      btn_step = 1'b0; btn_mode = 1'b0;
      repeat (int'($urandom_range(0, 12))) @(negedge clock);
    end
    repeat (12) @(negedge clock);
    wait_idle("random");
    if (!m_manual) press(0, 8);

    // Asynchronous reset during HIGH
    burst_en = 1'b1; burst_len = 8'd4;
    @(negedge clock); btn_step = 1'b1;
    t = 0;
    while (!step && t < 50) begin @(negedge clock); t++; end
    check("reset_step_timeout", t < 50, 1);
    #2 reset = 1'b1; btn_step = 1'b0;
    #1;
    check("async_change", change, 0);
    check("async_step", step, 0);
    check("async_manual", manual_mode, 0);
    check("async_busy", busy, 0);
    check("async_count", step_count, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // step_count wrap from FFFF
    press(0, 8);
    @(posedge clock); #1;
    force dut.count_q = 16'hFFFF;
    m_count = 16'hFFFF;
    @(posedge clock); #1;
    release dut.count_q;
    burst_en = 1'b0;
    measure("wrap", SH, PER, 1);
    check("wrap_zero", step_count, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
